// File: rtl/mem_responder.sv
// Memory responder: registered word array behind an IDLE/WAIT/ACCESS/DONE FSM; optional wait states under `MEM_WAIT_EN`.
// Latency: WAIT_CYC+2 edges with `MEM_WAIT_EN`, 2 edges without; Req is a level and is sampled only in IDLE.
module mem_responder #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req,
  input  logic [31:0] Addr,
  input  logic [3:0]  Byte_write,
  input  logic [31:0] Wdata,
  output logic [31:0] Rdata,
  output logic        Ready,
  output logic        Busy,
  output logic        Addr_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdat_q, wdat_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                aerr_q, aerr_d;
`ifdef MEM_WAIT_EN
  logic [3:0]          cnt_q, cnt_d;
`else
  logic                unused_wait_cyc;
  assign unused_wait_cyc = (WAIT_CYC != 0);
`endif

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rd_word;
  logic [31:0] merged;
  logic        mem_we;
  logic        req_err;

  // Misaligned or beyond the array: such an access never touches the array.
  assign req_err = (Addr[1:0] != 2'b00) || (|Addr[31:ADDR_W+2]);

  assign rd_word = mem[idx_q];
  assign mem_we  = (state_q == S_ACCESS) && !err_q;

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdat_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    be_d    = be_q;
    wdat_d  = wdat_q;
    err_d   = err_q;
    rdata_d = rdata_q;
`ifdef MEM_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          idx_d  = Addr[ADDR_W+1:2];
          be_d   = Byte_write;
          wdat_d = Wdata;
          err_d  = req_err;
`ifdef MEM_WAIT_EN
          if (WAIT_CYC > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYC - 1);
          end else begin
            state_d = S_ACCESS;
          end
`else
          state_d = S_ACCESS;
`endif
        end
      end
      S_WAIT: begin
`ifdef MEM_WAIT_EN
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
`else
        state_d = S_IDLE;
`endif
      end
      S_ACCESS: begin
        rdata_d = err_q ? 32'h0 : merged;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are flopped from the next state so they carry no input-to-output path.
    ready_d = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
    aerr_d  = (state_d == S_DONE) && err_d;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      be_q    <= 4'h0;
      wdat_q  <= 32'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      aerr_q  <= 1'b0;
`ifdef MEM_WAIT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wdat_q  <= wdat_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      aerr_q  <= aerr_d;
`ifdef MEM_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Array is deliberately outside the reset domain; contents survive reset.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdat_q[8*i +: 8];
      end
    end
  end

  assign Rdata    = rdata_q;
  assign Ready    = ready_q;
  assign Busy     = busy_q;
  assign Addr_err = aerr_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  localparam int TB_AW = 10;
`ifdef MEM_WAIT_EN
  localparam int TB_WAIT = 2;
  localparam int LAT     = TB_WAIT + 2;
`else
  localparam int TB_WAIT = 5;
  localparam int LAT     = 2;
`endif

  logic        Clk, Rst_n, Req;
  logic [31:0] Addr, Wdata, Rdata;
  logic [3:0]  Byte_write;
  logic        Ready, Busy, Addr_err;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 0;

  mem_responder #(.ADDR_W(TB_AW), .WAIT_CYC(TB_WAIT)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Addr(Addr), .Byte_write(Byte_write),
    .Wdata(Wdata), .Rdata(Rdata), .Ready(Ready), .Busy(Busy), .Addr_err(Addr_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request accepted at edge e0 completes LAT-1 edges later,
  // the array update happens at that completion edge, and the next acceptance needs an idle edge.
  int          n = 0;
  int          e0 = 0;
  bit          infl = 0;
  logic [31:0] m_addr, m_wd, m_word;
  logic [3:0]  m_be;
  bit          m_bad;
  int          m_idx;
  logic [31:0] mem_m [int];
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_ready = 1'b0, exp_busy = 1'b0, exp_err = 1'b0;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      infl = 0;
      exp_rdata = 32'h0; exp_ready = 1'b0; exp_busy = 1'b0; exp_err = 1'b0;
    end else begin
      n++;
      if (infl) begin
        if (n == e0 + LAT - 1) begin
          m_bad = (m_addr[1:0] != 2'b00) || ((m_addr >> (TB_AW + 2)) != 0);
          if (!m_bad) begin
            m_idx  = int'((m_addr >> 2) & ((32'd1 << TB_AW) - 1));
            m_word = mem_m.exists(m_idx) ? mem_m[m_idx] : 32'h0;
            for (int i = 0; i < 4; i++)
              if (m_be[i]) m_word[8*i +: 8] = m_wd[8*i +: 8];
            mem_m[m_idx] = m_word;
            exp_rdata = m_word;
          end else begin
            exp_rdata = 32'h0;
          end
        end else if (n == e0 + LAT) begin
          infl = 0;
        end
      end else if (Req) begin
        infl = 1; e0 = n;
        m_addr = Addr; m_be = Byte_write; m_wd = Wdata;
      end
      exp_busy  = infl;
      exp_ready = infl && (n == e0 + LAT - 1);
      exp_err   = exp_ready && m_bad;
    end
  end

  always @(negedge Clk) begin
    if (cmp_on) begin
      chk("cyc_ready", {31'b0, Ready}, {31'b0, exp_ready});
      chk("cyc_busy", {31'b0, Busy}, {31'b0, exp_busy});
      chk("cyc_err", {31'b0, Addr_err}, {31'b0, exp_err});
      chk("cyc_rdata", Rdata, exp_rdata);
    end
  end

  task automatic wait_rdy(input string name, input int exp_edges,
                          input logic [31:0] exp_rd, input logic exp_e);
    int edges = 0;
    bit got = 0;
    while (!got && edges < 60) begin
      @(negedge Clk);
      edges++;
      if (Ready) got = 1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_timeout: no Ready within %0d edges", name, edges);
    end else begin
      total--;
      chk({name, "_lat"}, edges, exp_edges);
      chk({name, "_rdata"}, Rdata, exp_rd);
      chk({name, "_err"}, {31'b0, Addr_err}, {31'b0, exp_e});
    end
  endtask

  task automatic txn(input string name, input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_e,
                     input bit hold);
    @(negedge Clk);
    Addr = a; Byte_write = be; Wdata = wd; Req = 1'b1;
    wait_rdy(name, LAT, exp_rd, exp_e);
    if (!hold) Req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Rst_n = 1'b0; Req = 1'b0; Addr = 32'h0; Byte_write = 4'h0; Wdata = 32'h0;
    repeat (3) @(negedge Clk);
    chk("rst_rdata", Rdata, 32'h0);
    chk("rst_ready", {31'b0, Ready}, 32'h0);
    chk("rst_busy", {31'b0, Busy}, 32'h0);
    chk("rst_err", {31'b0, Addr_err}, 32'h0);
    #2 Rst_n = 1'b1;
    cmp_on = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("idle_noready", {31'b0, Ready | Busy}, 32'h0);
    end

    txn("st10", 32'h10, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0);
    txn("ld10", 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    txn("st20", 32'h20, 4'hF, 32'h11223344, 32'h11223344, 1'b0, 0);
    txn("lane20", 32'h20, 4'b0101, 32'hAABBCCDD, 32'h11BB33DD, 1'b0, 0);
    txn("ld20", 32'h20, 4'h0, 32'h0, 32'h11BB33DD, 1'b0, 0);
    txn("mis22", 32'h22, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
    txn("ld20b", 32'h20, 4'h0, 32'h0, 32'h11BB33DD, 1'b0, 0);
    txn("oor", 32'h00001000, 4'h0, 32'h0, 32'h0, 1'b1, 0);

    // Req held through DONE: next request is accepted after one idle cycle.
    txn("st40", 32'h40, 4'hF, 32'h0A0B0C0D, 32'h0A0B0C0D, 1'b0, 1);
    Addr = 32'h40; Byte_write = 4'h0; Wdata = 32'h0;
    wait_rdy("held_ld40", LAT + 1, 32'h0A0B0C0D, 1'b0);
    Req = 1'b0;

    // Reset before the access edge aborts the store.
    txn("st30", 32'h30, 4'hF, 32'hCAFE0001, 32'hCAFE0001, 1'b0, 0);
    @(negedge Clk);
    Addr = 32'h30; Byte_write = 4'hF; Wdata = 32'h55555555; Req = 1'b1;
    @(negedge Clk);
    chk("abort_busy_pre", {31'b0, Busy}, 32'h1);
    #2 Rst_n = 1'b0; Req = 1'b0;
    #1;
    chk("abort_busy", {31'b0, Busy}, 32'h0);
    chk("abort_ready", {31'b0, Ready}, 32'h0);
    chk("abort_rdata", Rdata, 32'h0);
    @(negedge Clk);
    #2 Rst_n = 1'b1;
    txn("ld30", 32'h30, 4'h0, 32'h0, 32'hCAFE0001, 1'b0, 0);

    // Reset during DONE keeps the completed write.
    txn("st34", 32'h34, 4'hF, 32'h12345678, 32'h12345678, 1'b0, 0);
    #2 Rst_n = 1'b0;
    #1;
    chk("done_rst_ready", {31'b0, Ready}, 32'h0);
    @(negedge Clk);
    #2 Rst_n = 1'b1;
    txn("ld34", 32'h34, 4'h0, 32'h0, 32'h12345678, 1'b0, 0);

    repeat (3) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
